// File: rtl/cpu_pkg.sv
// Shared IF/ID definitions: word widths, NOP encoding, two-word opcode class,
// buffer FSM states and the registered decode packet.
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD  = 16'h4000;
  localparam logic [2:0]         IMM_CLASS = 3'b110;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_IMM = 1'b1
  } fd_state_e;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] imm;
    logic               has_imm;
    logic [PC_W-1:0]    pc1;
  } fd_packet_t;

  // An opcode word in the immediate class is completed by the next fetched word.
  function automatic logic needs_imm(input logic [INSTR_W-1:0] word);
    return word[OPC_HI:OPC_LO] == IMM_CLASS;
  endfunction
endpackage

// File: rtl/fetch_decode_buffer.sv
// IF/ID register: joins opcode+immediate word pairs into one decode packet,
// with stall (hold everything) and flush (drop everything, present a bubble).
module fetch_decode_buffer
  import cpu_pkg::*;
#(
  parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
  parameter int                 PC_W     = cpu_pkg::PC_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic [INSTR_W-1:0] fetch_word,
  input  logic [PC_W-1:0]    fetch_pc_plus_one,
  input  logic               stall,
  input  logic               flush,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instruction,
  output logic [INSTR_W-1:0] dec_immediate,
  output logic               dec_has_imm,
  output logic [PC_W-1:0]    dec_pc_plus_one,
  output logic               fetch_need_imm,
  output fd_state_e          dbg_state
);

  // dec_valid qualifies the dec_* packet for exactly the cycles it is high; there is
  // no ready back from decode, backpressure is expressed only through stall.
  localparam fd_packet_t BUBBLE = '{
    valid:   1'b0,
    instr:   NOP_WORD,
    imm:     '0,
    has_imm: 1'b0,
    pc1:     '0
  };

  fd_state_e          state, state_n;
  logic [INSTR_W-1:0] pend_op, pend_op_n;
  fd_packet_t         pkt, pkt_n;

  always_comb begin
    state_n   = state;
    pend_op_n = pend_op;
    pkt_n     = pkt;
    if (flush) begin
      state_n   = IDLE;
      pend_op_n = '0;
      pkt_n     = BUBBLE;
    end else if (!stall) begin
      pkt_n = BUBBLE;
      case (state)
        IDLE: begin
          if (fetch_valid) begin
            if (needs_imm(fetch_word)) begin
              pend_op_n = fetch_word;
              state_n   = WAIT_IMM;
            end else begin
              pkt_n = '{valid: 1'b1, instr: fetch_word, imm: '0,
                        has_imm: 1'b0, pc1: fetch_pc_plus_one};
            end
          end
        end
        WAIT_IMM: begin
          // Second word is taken verbatim, whatever its opcode class.
          if (fetch_valid) begin
            pkt_n = '{valid: 1'b1, instr: pend_op, imm: fetch_word,
                      has_imm: 1'b1, pc1: fetch_pc_plus_one};
            pend_op_n = '0;
            state_n   = IDLE;
          end
        end
        default: begin
          state_n   = IDLE;
          pend_op_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pend_op <= '0;
      pkt     <= BUBBLE;
    end else begin
      state   <= state_n;
      pend_op <= pend_op_n;
      pkt     <= pkt_n;
    end
  end

  assign dec_valid       = pkt.valid;
  assign dec_instruction = pkt.instr;
  assign dec_immediate   = pkt.imm;
  assign dec_has_imm     = pkt.has_imm;
  assign dec_pc_plus_one = pkt.pc1;
  assign fetch_need_imm  = (state == WAIT_IMM);
  assign dbg_state       = state;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed bench for fetch_decode_buffer: expected packets are queued as words are
// driven and a monitor pops one each time a fresh valid packet appears.
module tb_fetch_decode_buffer;
  import cpu_pkg::*;

  localparam int PW = 16 + 16 + 1 + 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [15:0] fetch_word;
  logic [31:0] fetch_pc_plus_one;
  logic        stall;
  logic        flush;
  logic        dec_valid;
  logic [15:0] dec_instruction;
  logic [15:0] dec_immediate;
  logic        dec_has_imm;
  logic [31:0] dec_pc_plus_one;
  logic        fetch_need_imm;
  fd_state_e   dbg_state;

  logic [PW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic stall_q = 1'b0;

  fetch_decode_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_valid       (fetch_valid),
    .fetch_word        (fetch_word),
    .fetch_pc_plus_one (fetch_pc_plus_one),
    .stall             (stall),
    .flush             (flush),
    .dec_valid         (dec_valid),
    .dec_instruction   (dec_instruction),
    .dec_immediate     (dec_immediate),
    .dec_has_imm       (dec_has_imm),
    .dec_pc_plus_one   (dec_pc_plus_one),
    .fetch_need_imm    (fetch_need_imm),
    .dbg_state         (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Driver tasks: apply one cycle of inputs, return #1 after the edge.
  task automatic drive(input logic v, input logic [15:0] w, input logic [31:0] pc,
                       input logic st, input logic fl);
    fetch_valid       = v;
    fetch_word        = w;
    fetch_pc_plus_one = pc;
    stall             = st;
    flush             = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pkt(input logic [15:0] ins, input logic [15:0] imm,
                            input logic has, input logic [31:0] pc);
    exp_q.push_back({ins, imm, has, pc});
  endtask

  task automatic check_bubble(input string name, input logic need);
    check({name, "_valid"}, PW'(dec_valid), PW'(1'b0));
    check({name, "_instr"}, PW'(dec_instruction), PW'(16'h4000));
    check({name, "_need_imm"}, PW'(fetch_need_imm), PW'(need));
  endtask

  // Scoreboard monitor: a valid packet seen after a non-stalled edge is a new one.
  always @(posedge clk) stall_q <= stall;

  always @(negedge clk) begin
    if (dec_valid && !stall_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt", {dec_instruction, dec_immediate, dec_has_imm, dec_pc_plus_one}, '0);
      end else begin
        check("pkt", {dec_instruction, dec_immediate, dec_has_imm, dec_pc_plus_one},
              exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    fetch_valid = 1'b0; fetch_word = '0; fetch_pc_plus_one = '0;
    stall = 1'b0; flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_bubble("reset", 1'b0);
    check("reset_imm", PW'(dec_immediate), '0);
    check("reset_has_imm", PW'(dec_has_imm), '0);
    check("reset_pc1", PW'(dec_pc_plus_one), '0);
    reset = 1'b0;
    drive(0, 16'h0000, 0, 0, 0);

    // One-word instruction, latency 1
    expect_pkt(16'h2005, 16'h0000, 1'b0, 32'd33);
    drive(1, 16'h2005, 33, 0, 0);
    check("one_word_need_imm", PW'(fetch_need_imm), '0);

    // Two-word pair
    drive(1, 16'hC123, 40, 0, 0);
    check_bubble("pair_first", 1'b1);
    expect_pkt(16'hC123, 16'h00FF, 1'b1, 32'd41);
    drive(1, 16'h00FF, 41, 0, 0);
    check("pair_done_need_imm", PW'(fetch_need_imm), '0);

    // Gaps while waiting; the NOP encoding is accepted as an immediate
    drive(1, 16'hC123, 50, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'h9999, 51, 0, 0);
      check_bubble("wait_gap", 1'b1);
    end
    expect_pkt(16'hC123, 16'h4000, 1'b1, 32'd54);
    drive(1, 16'h4000, 54, 0, 0);

    // Stall holds a presented packet, then releases to the next word
    expect_pkt(16'h2005, 16'h0000, 1'b0, 32'd60);
    drive(1, 16'h2005, 60, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'h1234 + 16'(i), 61, 1, 0);
      check("stall_hold_valid", PW'(dec_valid), PW'(1'b1));
      check("stall_hold_pkt", {dec_instruction, dec_immediate, dec_has_imm, dec_pc_plus_one},
            {16'h2005, 16'h0000, 1'b0, 32'd60});
    end
    expect_pkt(16'h3333, 16'h0000, 1'b0, 32'd62);
    drive(1, 16'h3333, 62, 0, 0);

    // Stall inside a pair keeps the pending opcode and ignores the word
    drive(1, 16'hC0DE, 70, 0, 0);
    drive(1, 16'h7777, 71, 1, 0);
    check_bubble("stall_in_pair", 1'b1);
    expect_pkt(16'hC0DE, 16'h0042, 1'b1, 32'd72);
    drive(1, 16'h0042, 72, 0, 0);

    // Flush with stall mid-pair drops the pending opcode and the same-cycle word
    drive(1, 16'hC123, 80, 0, 0);
    drive(1, 16'h1111, 81, 1, 1);
    check_bubble("flush_stall", 1'b0);
    check("flush_state", PW'(dbg_state), PW'(IDLE));
    drive(0, 16'h0000, 82, 0, 0);
    check_bubble("after_flush", 1'b0);

    // Flush over a held packet, one-word word discarded
    expect_pkt(16'h0101, 16'h0000, 1'b0, 32'd90);
    drive(1, 16'h0101, 90, 0, 0);
    drive(1, 16'h0202, 91, 0, 1);
    check_bubble("flush_pkt", 1'b0);

    // Opcode-class boundaries: 111 and 101 are one-word, 110 needs an immediate
    expect_pkt(16'hE000, 16'h0000, 1'b0, 32'd100);
    drive(1, 16'hE000, 100, 0, 0);
    expect_pkt(16'hBFFF, 16'h0000, 1'b0, 32'd101);
    drive(1, 16'hBFFF, 101, 0, 0);
    drive(1, 16'hDFFF, 102, 0, 0);
    check_bubble("class_110", 1'b1);
    expect_pkt(16'hDFFF, 16'hC000, 1'b1, 32'd103);
    drive(1, 16'hC000, 103, 0, 0);

    // Back-to-back pairs: one packet per two valid words
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'hC001 + 16'(i), 110 + 2 * i, 0, 0);
      check("b2b_need_imm", PW'(fetch_need_imm), PW'(1'b1));
      expect_pkt(16'hC001 + 16'(i), 16'h00A0 + 16'(i), 1'b1, 32'(111 + 2 * i));
      drive(1, 16'h00A0 + 16'(i), 111 + 2 * i, 0, 0);
      check("b2b_valid", PW'(dec_valid), PW'(1'b1));
    end

    // Asynchronous reset in the middle of a pair
    drive(1, 16'hC123, 120, 0, 0);
    fetch_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_bubble("async_reset", 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    expect_pkt(16'h0055, 16'h0000, 1'b0, 32'd130);
    drive(1, 16'h0055, 130, 0, 0);
    drive(0, 16'h0000, 0, 0, 0);
    drive(0, 16'h0000, 0, 0, 0);

    check("queue_empty", PW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
